// File: rtl/ulpi_pkg.sv
// ULPI register-access shared definitions: TX command prefixes,
// controller state encoding and the NOOP bus byte.
package ulpi_pkg;

  localparam logic [1:0] CMD_REGW = 2'b10;
  localparam logic [1:0] CMD_REGR = 2'b11;
  localparam logic [7:0] NOOP     = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_CMD,
    S_W_DATA,
    S_W_STP,
    S_R_CMD,
    S_R_TURN,
    S_R_DATA,
    S_R_WAIT,
    S_RETRY
  } state_t;

  function automatic logic [7:0] tx_cmd(
    input logic       rd,
    input logic [5:0] addr
  );
    return {(rd ? CMD_REGR : CMD_REGW), addr};
  endfunction

endpackage

// File: rtl/ulpi_timeout.sv
// Per-state dwell counter for the ULPI register controller; flags
// expiry on the TIMEOUT_CYCLES-th consecutive cycle in a busy state.
module ulpi_timeout
  import ulpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic   clk,
  input  logic   rst_n,
  input  state_t i_state,
  output logic   o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  state_t        r_last;
  logic [CW-1:0] w_cnt;
  logic          w_run;

  assign w_run = (i_state != S_IDLE);
  // A state change restarts the count in the same cycle it is seen.
  assign w_cnt = (i_state != r_last) ? '0 : r_cnt;
  assign o_expired = w_run &&
    (w_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_last <= S_IDLE;
    end else begin
      r_last <= i_state;
      if (w_run && !o_expired)
        r_cnt <= w_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

endmodule

// File: rtl/ulpi_reg_ctrl.sv
// ULPI link-side PHY register read/write controller.
// Optional abort-on-timeout via `define ULPI_REG_CTRL_TIMEOUT_EN.
module ulpi_reg_ctrl
  import ulpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       WD,
  input  logic       RD,
  input  logic [5:0] ADDR,
  input  logic [7:0] REG_DATA_IN,
  output logic [7:0] REG_DATA_OUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  input  logic       DIR,
  input  logic       NXT,
  input  logic [7:0] DATA_I,
  output logic       STP,
  output logic [7:0] DATA_O,
  output logic       DATA_OE
);

  state_t     r_state;
  logic       r_rd;
  logic [5:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic [7:0] r_dout;
  logic       r_oe;
  logic       r_stp;
  logic       r_done;
  logic       w_oe;

  // The PHY owns the bus whenever DIR is high, regardless of state.
  assign w_oe = r_oe & ~DIR;

`ifdef ULPI_REG_CTRL_TIMEOUT_EN
  logic r_err;
  logic w_to;

  ulpi_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst),
    .i_state   (r_state),
    .o_expired (w_to)
  );

  assign ERR = r_err;
`else
  logic w_unused_to;

  assign w_unused_to = (TIMEOUT_CYCLES == 0);
  assign ERR = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_dout  <= NOOP;
      r_oe    <= 1'b0;
      r_stp   <= 1'b0;
      r_done  <= 1'b0;
`ifdef ULPI_REG_CTRL_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_stp  <= 1'b0;
`ifdef ULPI_REG_CTRL_TIMEOUT_EN
      r_err  <= 1'b0;
      if (w_to) begin
        r_stp   <= w_oe;
        r_err   <= 1'b1;
        r_oe    <= 1'b0;
        r_dout  <= NOOP;
        r_state <= S_IDLE;
      end else
`endif
      unique case (r_state)
        S_IDLE: begin
          if ((WD || RD) && !DIR) begin
            r_rd    <= !WD;
            r_addr  <= ADDR;
            r_wdata <= REG_DATA_IN;
            r_dout  <= tx_cmd(!WD, ADDR);
            r_oe    <= 1'b1;
            r_state <= WD ? S_W_CMD : S_R_CMD;
          end
        end
        S_W_CMD: begin
          if (DIR) begin
            r_oe    <= 1'b0;
            r_dout  <= NOOP;
            r_state <= S_RETRY;
          end else if (NXT) begin
            r_dout  <= r_wdata;
            r_state <= S_W_DATA;
          end
        end
        S_W_DATA: begin
          if (DIR) begin
            r_oe    <= 1'b0;
            r_dout  <= NOOP;
            r_state <= S_RETRY;
          end else if (NXT) begin
            r_dout  <= NOOP;
            r_stp   <= 1'b1;
            r_state <= S_W_STP;
          end
        end
        S_W_STP: begin
          r_oe    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_R_CMD: begin
          if (DIR) begin
            r_oe    <= 1'b0;
            r_dout  <= NOOP;
            r_state <= S_RETRY;
          end else if (NXT) begin
            r_oe    <= 1'b0;
            r_dout  <= NOOP;
            r_state <= S_R_TURN;
          end
        end
        S_R_TURN: begin
          if (DIR)
            r_state <= S_R_DATA;
        end
        S_R_DATA: begin
          // NXT with DIR means an RX packet pre-empted the read.
          if (DIR && !NXT) begin
            r_rdata <= DATA_I;
            r_state <= S_R_WAIT;
          end else begin
            r_state <= S_RETRY;
          end
        end
        S_R_WAIT: begin
          if (!DIR) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_RETRY: begin
          if (!DIR) begin
            r_dout  <= tx_cmd(r_rd, r_addr);
            r_oe    <= 1'b1;
            r_state <= r_rd ? S_R_CMD : S_W_CMD;
          end
        end
        default: begin
          r_oe    <= 1'b0;
          r_dout  <= NOOP;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign REG_DATA_OUT = r_rdata;
  assign BUSY         = (r_state != S_IDLE);
  assign DONE         = r_done;
  assign STP          = r_stp;
  assign DATA_O       = r_dout;
  assign DATA_OE      = w_oe;

endmodule

// File: doc/ulpi_reg_ctrl.md
ULPI_REG_CTRL -- requirements
Module: ulpi_reg_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles a transaction waits on NXT/DIR before abort (used only with timeout feature).
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 WD  in  1  register write request; RD  in  1  register read request.
REQ-005 ADDR  in  6  register address; REG_DATA_IN  in  8  write data.
REQ-006 REG_DATA_OUT  out  8  last read data; BUSY  out  1  transaction in progress; DONE  out  1  one-cycle completion pulse; ERR  out  1  one-cycle timeout pulse.
REQ-007 DIR  in  1; NXT  in  1; DATA_I  in  8  ULPI pins from PHY.
REQ-008 STP  out  1; DATA_O  out  8; DATA_OE  out  1  ULPI link drive side; tristate lives in top level.

Function
REQ-009 States: IDLE, W_CMD, W_DATA, W_STP, R_CMD, R_TURN, R_DATA, R_WAIT, RETRY.
REQ-010 IDLE: request accepted when (WD|RD)=1 and DIR=0; ADDR/REG_DATA_IN latched same edge; BUSY=1 from next cycle.
REQ-011 WD and RD both high: write wins, read dropped.
REQ-012 WD/RD while BUSY=1 or DIR=1 in IDLE: ignored, not queued.
REQ-013 W_CMD: DATA_O=8'b10 & addr, DATA_OE=1; stay until NXT=1, then W_DATA.
REQ-014 W_DATA: DATA_O=latched data; stay until NXT=1, then W_STP.
REQ-015 W_STP: STP=1 one cycle, DATA_O=8'h00; then IDLE with DONE=1 that cycle; write latency with immediate NXT = 3 cycles accept-to-DONE.
REQ-016 R_CMD: DATA_O=8'b11 & addr, DATA_OE=1; on NXT=1 go R_TURN.
REQ-017 R_TURN: DATA_OE=0; requires DIR=1 (bus turnaround), then R_DATA.
REQ-018 R_DATA: DIR=1,NXT=0 -> REG_DATA_OUT<=DATA_I, go R_WAIT; DIR=1,NXT=1 -> RX packet, go RETRY.
REQ-019 R_WAIT: DATA_OE=0 until DIR=0, then IDLE with DONE=1.
REQ-020 DIR=1 seen in W_CMD, W_DATA or R_CMD: DATA_OE=0 same cycle (combinational), go RETRY; no STP.
REQ-021 RETRY: DATA_OE=0, wait DIR=0 then restart original command (W_CMD/R_CMD) with latched addr/data; retries unlimited.
REQ-022 DATA_OE SHALL be 0 whenever DIR=1, in every state.
REQ-023 REG_DATA_OUT SHALL change only in R_DATA capture; held otherwise.
REQ-024 DONE and ERR SHALL never assert in the same cycle.

Reset
REQ-025 rst=0 asynchronously forces IDLE; BUSY=0, DONE=0, ERR=0, STP=0, DATA_OE=0, DATA_O=8'h00, REG_DATA_OUT=8'h00, latches cleared.
REQ-026 Reset mid-transaction: no STP issued, transaction lost, no DONE after release.
REQ-027 First request accepted on first edge after rst deasserts with DIR=0.

Configuration
REQ-028 Macro ULPI_REG_CTRL_TIMEOUT_EN defined: counter clears on state change, increments each cycle in a non-IDLE state; reaching TIMEOUT_CYCLES -> DATA_OE=0, STP=1 one cycle if link was driving, ERR=1, return IDLE, no DONE.
REQ-029 Macro undefined: no counter logic, ERR tied 0, controller waits indefinitely.

Structure
REQ-030 Shared package ulpi_pkg SHALL hold TX CMD prefixes (REGW=2'b10, REGR=2'b11), state encodings, NOOP byte 8'h00.
REQ-031 One sub-module natural: ulpi_timeout (counter + compare), instantiated only under ULPI_REG_CTRL_TIMEOUT_EN.

Verification
REQ-032 WD, ADDR=6'h04, REG_DATA_IN=8'h45, PHY NXT immediate -> DATA_O 8'h84 then 8'h45, STP one cycle, DONE 3 cycles after accept.
REQ-033 RD, ADDR=6'h0A, PHY NXT, DIR turnaround, DATA_I=8'h5A -> REG_DATA_OUT=8'h5A, DONE after DIR falls, DATA_OE=0 throughout DIR=1.
REQ-034 WD and RD same cycle, ADDR=6'h16 -> only 8'h96 write command seen, single DONE.
REQ-035 DIR rises during W_CMD for 4 cycles -> DATA_OE drops same cycle, no STP, command 8'h84 reissued after DIR=0, one DONE.
REQ-036 With ULPI_REG_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=8, NXT held 0 -> ERR pulse after 8 cycles in W_CMD, STP=1, IDLE, no DONE.
REQ-037 rst low asynchronously during W_DATA -> all outputs to reset values before next edge, no DONE after release.
